// File: rtl/force_window_ctrl_pkg.sv
// rtl/force_window_ctrl_pkg.sv - shared types and defaults for the force window controller
package force_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] val;
    logic [DEF_WIDTH-1:0] mask;
    logic [DEF_CNT_W-1:0] delay;
    logic [DEF_CNT_W-1:0] len;
  } cmd_t;

endpackage

// File: rtl/force_window_ctrl_if.sv
// rtl/force_window_ctrl_if.sv - command, datapath and status bundle for the force window controller
interface force_window_ctrl_if
  import force_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_val;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_delay;
  logic [CNT_W-1:0] cmd_len;
  logic             cmd_abort;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             forcing;
  logic             busy;
  logic             done;
  logic             done_aborted;

  // Producer side: issues commands and drives the datapath net
  modport master (
    output cmd_valid, cmd_val, cmd_mask, cmd_delay, cmd_len, cmd_abort, data_in,
    input  cmd_ready, data_out, forcing, busy, done, done_aborted
  );

  // Controller side
  modport slave (
    input  cmd_valid, cmd_val, cmd_mask, cmd_delay, cmd_len, cmd_abort, data_in,
    output cmd_ready, data_out, forcing, busy, done, done_aborted
  );

endinterface

// File: rtl/force_mask_mux.sv
// rtl/force_mask_mux.sv - combinational per-bit override mux
module force_mask_mux #(
  parameter int WIDTH = 8
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] data_o
);

  // Masked bits take the forced value only while the window is open
  always_comb begin
    data_o = data_i;
    if (sel_i) begin
      data_o = (data_i & ~mask_i) | (val_i & mask_i);
    end
  end

endmodule

// File: rtl/force_window_ctrl.sv
// rtl/force_window_ctrl.sv - timed force/release override sequencer for a WIDTH-bit net
module force_window_ctrl
  import force_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  force_window_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             done_q, done_d;
  logic             done_ab_q, done_ab_d;

  // State, counter and captured command; reset closes any open window at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      val_q     <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      done_ab_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      val_q     <= val_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      done_ab_q <= done_ab_d;
    end
  end

  // Next-state logic; counters exit or reload at 1 so they never wrap
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    val_d     = val_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    done_ab_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Abort is ignored here, even alongside an accepted command
        if (bus.cmd_valid) begin
          val_d  = bus.cmd_val;
          mask_d = bus.cmd_mask;
          len_d  = bus.cmd_len;
          if (bus.cmd_delay != '0) begin
            state_d = WAIT;
            cnt_d   = bus.cmd_delay;
          end else if (bus.cmd_len != '0) begin
            state_d = FORCE;
            cnt_d   = bus.cmd_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.cmd_abort) begin
          state_d   = IDLE;
          cnt_d     = '0;
          done_d    = 1'b1;
          done_ab_d = 1'b1;
        end else if (cnt_q == CNT_ONE) begin
          if (len_q != '0) begin
            state_d = FORCE;
            cnt_d   = len_q;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      FORCE: begin
        // The last forced cycle completes normally even if abort arrives with it
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (bus.cmd_abort) begin
          state_d   = IDLE;
          cnt_d     = '0;
          done_d    = 1'b1;
          done_ab_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status decoded straight from the state register
  always_comb begin
    bus.forcing      = (state_q == FORCE);
    bus.busy         = (state_q != IDLE);
    bus.cmd_ready    = (state_q == IDLE);
    bus.done         = done_q;
    bus.done_aborted = done_ab_q;
  end

  force_mask_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel_i (state_q == FORCE),
    .data_i(bus.data_in),
    .val_i (val_q),
    .mask_i(mask_q),
    .data_o(bus.data_out)
  );

endmodule

// File: tb/tb_force_window_ctrl.sv
// tb/tb_force_window_ctrl.sv - self-checking bench for force_window_ctrl
module tb_force_window_ctrl;
  import force_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  force_window_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();

  force_window_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // One command from acceptance through its done cycle, checked against a
  // cycle-index model: window occupies delay+1..end, done lands on end+1.
  // abort_k: -1 none, 0 asserted with the accept, k>0 asserted in cycle k.
  // din_mode: 0 random, 1 fixed din_base, 2 din_base*k.
  task automatic run_cmd(input logic [7:0] val, input logic [7:0] mask,
                         input int delay, input int len, input int abort_k,
                         input int din_mode, input logic [7:0] din_base, input bit now);
    int end_nat, end_k;
    bit aborted, exp_f;
    logic [7:0] din, exp_out;
    end_nat = delay + len;
    aborted = (abort_k >= 1) && (abort_k <= end_nat) && !(len > 0 && abort_k == end_nat);
    end_k   = aborted ? abort_k : end_nat;
    if (!now) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_val   = val;
    bus.cmd_mask  = mask;
    bus.cmd_delay = 8'(delay);
    bus.cmd_len   = 8'(len);
    bus.cmd_abort = (abort_k == 0);
    #1;
    total_cnt++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", bus.cmd_ready);
    else pass_cnt++;
    @(posedge clk);
    for (int k = 1; k <= end_k + 1; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_abort = (k == abort_k);
      if (din_mode == 0)      din = 8'($urandom);
      else if (din_mode == 1) din = din_base;
      else                    din = 8'(din_base * k);
      bus.data_in = din;
      #1;
      exp_f = (k >= delay + 1) && (k <= end_k);
      for (int b = 0; b < 8; b++) exp_out[b] = (exp_f && mask[b]) ? val[b] : din[b];
      total_cnt++;
      if (bus.forcing !== exp_f)
        $display("FAIL forcing: d=%0d l=%0d k=%0d got %b want %b", delay, len, k, bus.forcing, exp_f);
      else pass_cnt++;
      total_cnt++;
      if (bus.data_out !== exp_out)
        $display("FAIL data_out: d=%0d l=%0d k=%0d got %h want %h", delay, len, k, bus.data_out, exp_out);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== (k <= end_k))
        $display("FAIL busy: d=%0d l=%0d k=%0d got %b want %b", delay, len, k, bus.busy, (k <= end_k));
      else pass_cnt++;
      total_cnt++;
      if (bus.cmd_ready !== (k > end_k))
        $display("FAIL cmd_ready: d=%0d l=%0d k=%0d got %b want %b", delay, len, k, bus.cmd_ready, (k > end_k));
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== (k == end_k + 1))
        $display("FAIL done: d=%0d l=%0d k=%0d got %b want %b", delay, len, k, bus.done, (k == end_k + 1));
      else pass_cnt++;
      total_cnt++;
      if (bus.done_aborted !== (k == end_k + 1 && aborted))
        $display("FAIL done_aborted: d=%0d l=%0d k=%0d got %b want %b", delay, len, k,
                 bus.done_aborted, (k == end_k + 1 && aborted));
      else pass_cnt++;
    end
    bus.cmd_abort = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_val   = '0;
    bus.cmd_mask  = '0;
    bus.cmd_delay = '0;
    bus.cmd_len   = '0;
    bus.cmd_abort = 1'b0;
    bus.data_in   = 8'h5C;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.forcing !== 1'b0) $display("FAIL reset_forcing: got %b want 0", bus.forcing); else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0 || bus.done_aborted !== 1'b0)
      $display("FAIL reset_done: got %b%b want 00", bus.done, bus.done_aborted);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'h5C) $display("FAIL reset_data_out: got %h want 5c", bus.data_out); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_cmd(8'hFF, 8'hFF, 2, 3, -1, 1, 8'h00, 1'b0);
  endtask

  task automatic test_single_bit();
    run_cmd(8'h01, 8'h01, 0, 1, -1, 1, 8'hA0, 1'b0);
  endtask

  task automatic test_nibble();
    run_cmd(8'h0F, 8'h0F, 0, 4, -1, 2, 8'h10, 1'b0);
  endtask

  task automatic test_abort();
    run_cmd(8'hC3, 8'hFF, 0, 10, 4, 0, 8'h00, 1'b0);
    run_cmd(8'hC3, 8'hFF, 0, 10, 10, 0, 8'h00, 1'b0);
    run_cmd(8'h3C, 8'hF0, 5, 2, 3, 0, 8'h00, 1'b0);
    run_cmd(8'h77, 8'hFF, 2, 2, 0, 0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd(8'hFF, 8'hFF, 0, 0, -1, 0, 8'h00, 1'b0);
    run_cmd(8'h55, 8'hFF, 1, 1, -1, 0, 8'h00, 1'b1);
    run_cmd(8'hAA, 8'h0F, 0, 2, -1, 0, 8'h00, 1'b1);
  endtask

  task automatic test_zero_mask_and_max();
    run_cmd(8'hFF, 8'h00, 1, 4, -1, 0, 8'h00, 1'b0);
    run_cmd(8'h96, 8'hFF, 255, 255, -1, 0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    cmd_t c;
    int   d, l, a;
    for (int i = 0; i < 40; i++) begin
      c.val  = 8'($urandom);
      c.mask = 8'($urandom);
      d = $urandom_range(0, 5);
      l = $urandom_range(0, 5);
      c.delay = 8'(d);
      c.len   = 8'(l);
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, d + l + 1)) : -1;
      run_cmd(c.val, c.mask, int'(c.delay), int'(c.len), a, 0, 8'h00, (i > 0) && ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_val   = 8'hFF;
    bus.cmd_mask  = 8'hFF;
    bus.cmd_delay = 8'd0;
    bus.cmd_len   = 8'd10;
    bus.data_in   = 8'h12;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total_cnt++;
    if (bus.forcing !== 1'b1) $display("FAIL pre_reset_forcing: got %b want 1", bus.forcing); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.forcing !== 1'b0) $display("FAIL async_reset_forcing: got %b want 0", bus.forcing); else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'h12) $display("FAIL async_reset_data_out: got %h want 12", bus.data_out); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL post_reset_done: k=%0d got %b want 0", k, bus.done); else pass_cnt++;
      total_cnt++;
      if (bus.cmd_ready !== 1'b1) $display("FAIL post_reset_ready: k=%0d got %b want 1", k, bus.cmd_ready);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_bit();
    test_nibble();
    test_abort();
    test_back_to_back();
    test_zero_mask_and_max();
    test_random();
    test_reset_mid();
    test_basic();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
